// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the MIPS execute stage.
// Sequences 32-iteration MULT/MULTU (shift-add) and DIV/DIVU (restoring)
// operations, owns the HI/LO registers and services MTHI/MTLO writes.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   md_start, md_op    request valid and opcode (1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                      5 MTHI, 6 MTLO, others no-op)
//   md_op_x, md_op_y   rs / rt operands
//   md_flush           abort in-flight operation, drop same-cycle start
//   md_rd_en           decode stage holds an MFHI/MFLO
//   md_busy, md_stall  iterative op in progress; read hazard stall
//   hi, lo             architectural HI/LO registers
module mdu_ctrl #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_op_x,
    input  logic [WIDTH-1:0] md_op_y,
    input  logic             md_flush,
    input  logic             md_rd_en,
    output logic             md_busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {partial product high, multiplier shifting out}.
    // DIV: {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // MUL: |multiplicand|. DIV: |divisor|.
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   x_raw_q, x_raw_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_op, iter_op, mul_op;
    logic               x_neg, y_neg;
    logic [WIDTH-1:0]   x_abs, y_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        signed_op = (md_op == OpMult) || (md_op == OpDiv);
        mul_op    = (md_op == OpMult) || (md_op == OpMultu);
        iter_op   = mul_op || (md_op == OpDiv) || (md_op == OpDivu);
        x_neg     = signed_op & md_op_x[WIDTH-1];
        y_neg     = signed_op & md_op_y[WIDTH-1];
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        x_abs     = x_neg ? -md_op_x : md_op_x;
        y_abs     = y_neg ? -md_op_y : md_op_y;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_sub   = div_shift - {1'b0, mcand_q};

        prod_neg  = -acc_q;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        x_raw_d  = x_raw_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            StIdle: begin
                if (md_start && !md_flush) begin
                    if (iter_op) begin
                        state_d  = mul_op ? StMul : StDiv;
                        cnt_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, mul_op ? y_abs : x_abs};
                        mcand_d  = mul_op ? x_abs : y_abs;
                        x_raw_d  = md_op_x;
                        qsign_d  = x_neg ^ y_neg;
                        rsign_d  = x_neg;
                        is_div_d = !mul_op;
                        div0_d   = (md_op_y == '0);
                    end else if (md_op == OpMthi) begin
                        hi_d = md_op_x;
                    end else if (md_op == OpMtlo) begin
                        lo_d = md_op_x;
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) state_d = StFix;
            end
            StDiv: begin
                if (div_ge) acc_d = {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) state_d = StFix;
            end
            default: begin // StFix
                state_d = StIdle;
                if (!is_div_q) begin
                    {hi_d, lo_d} = qsign_q ? prod_neg : acc_q;
                end else if (div0_q) begin
                    lo_d = DIV0_LO;
                    hi_d = x_raw_q;
                end else begin
                    lo_d = qsign_q ? -quo : quo;
                    hi_d = rsign_q ? -rem : rem;
                end
            end
        endcase

        // Flush abandons the operation, including its FIX write-back.
        if (md_flush && state_q != StIdle) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            x_raw_q  <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            x_raw_q  <= x_raw_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md_busy  = (state_q != StIdle);
    assign md_stall = md_rd_en & md_busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus randomized ops, with expected
// HI/LO results queued at issue time and checked when md_busy falls.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        md_start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] md_op_x = '0;
    logic [31:0] md_op_y = '0;
    logic        md_flush = 1'b0;
    logic        md_rd_en = 1'b0;
    logic        md_busy, md_stall;
    logic [31:0] hi, lo;

    mdu_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .md_op_x  (md_op_x),
        .md_op_y  (md_op_y),
        .md_flush (md_flush),
        .md_rd_en (md_rd_en),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          len;
        bit          chk_len;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (op)
            3'd1: ref_result = sx * sy;
            3'd2: ref_result = ux * uy;
            default: begin
                if (y == 0) begin
                    ref_result = {x, 32'hFFFFFFFF};
                end else if (op == 3'd3) begin
                    q = sx / sy;
                    r = sx % sy;
                    ref_result = {r[31:0], q[31:0]};
                end else begin
                    ref_result = {32'(ux % uy), 32'(ux / uy)};
                end
            end
        endcase
    endfunction

    // Monitor: every falling edge of md_busy is a result presentation.
    initial begin
        int   bcnt = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (md_busy) begin
                bcnt++;
            end else if (prev) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result_hi", {32'b0, hi}, {32'b0, e.e_hi});
                    check("result_lo", {32'b0, lo}, {32'b0, e.e_lo});
                    if (e.chk_len) check("busy_len", 64'(bcnt), 64'(e.len));
                end
                bcnt = 0;
            end
            prev = md_busy;
        end
    end

    // Drive one request for exactly one acceptance edge; returns at the
    // negedge following that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        md_start = 1'b1;
        md_op    = op;
        md_op_x  = x;
        md_op_y  = y;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = 3'd0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!md_busy) break;
            @(negedge clk);
        end
        check("idle_wait", {63'b0, md_busy}, 64'd0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        exp_t        e;
        r = ref_result(op, x, y);
        e.e_hi = r[63:32];
        e.e_lo = r[31:0];
        e.len = 33;
        e.chk_len = 1'b1;
        sb_q.push_back(e);
        model_hi = r[63:32];
        model_lo = r[31:0];
        issue(op, x, y);
        wait_idle();
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] x);
        issue(op, x, 32'h0);
        if (op == 3'd5) model_hi = x;
        else            model_lo = x;
        check("mt_busy", {63'b0, md_busy}, 64'd0);
        check("mt_hi", {32'b0, hi}, {32'b0, model_hi});
        check("mt_lo", {32'b0, lo}, {32'b0, model_lo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       pick = 32'h80000000;
            1:       pick = 32'hFFFFFFFF;
            2:       pick = 32'h0;
            3:       pick = 32'h1;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   stall_cnt;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, md_busy}, 64'd0);
        check("rst_stall", {63'b0, md_stall}, 64'd0);

        run_op(3'd1, 32'hFFFFFFFD, 32'd7);
        check("mult_m3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        check("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd4, 32'd100, 32'd7);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf", {hi, lo}, 64'h00000000_80000000);
        run_op(3'd4, 32'h1234, 32'h0);
        check("divu_zero", {hi, lo}, 64'h00001234_FFFFFFFF);

        // Reserved opcode and MTHI under flush are both no-ops.
        issue(3'd7, 32'h77, 32'h1);
        check("rsvd_busy", {63'b0, md_busy}, 64'd0);
        @(negedge clk);
        md_start = 1'b1; md_op = 3'd5; md_op_x = 32'h99; md_flush = 1'b1;
        @(negedge clk);
        md_start = 1'b0; md_op = 3'd0; md_flush = 1'b0;
        check("flush_idle_mthi", {32'b0, hi}, {32'b0, model_hi});

        // Flush mid-MULT: HI/LO keep pre-operation values.
        run_mt(3'd6, 32'h55);
        e.e_hi = model_hi; e.e_lo = model_lo; e.len = 0; e.chk_len = 1'b0;
        sb_q.push_back(e);
        issue(3'd1, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        check("flush_busy", {63'b0, md_busy}, 64'd0);
        check("flush_lo", {32'b0, lo}, 64'h55);

        // Reset mid-MULT clears HI/LO.
        e.e_hi = '0; e.e_lo = '0; e.len = 0; e.chk_len = 1'b0;
        sb_q.push_back(e);
        issue(3'd1, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        check("rstmid_busy", {63'b0, md_busy}, 64'd0);
        check("rstmid_hilo", {hi, lo}, 64'd0);

        // Stall during DIV; MTHI while busy must be ignored.
        md_rd_en = 1'b1;
        begin
            logic [63:0] r;
            r = ref_result(3'd3, 32'hFFFFFF9C, 32'd7);
            e.e_hi = r[63:32]; e.e_lo = r[31:0]; e.len = 33; e.chk_len = 1'b1;
            sb_q.push_back(e);
            model_hi = r[63:32];
            model_lo = r[31:0];
        end
        issue(3'd3, 32'hFFFFFF9C, 32'd7);
        stall_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!md_busy) break;
            if (md_stall) stall_cnt++;
            if (i == 5) begin
                md_start = 1'b1; md_op = 3'd5; md_op_x = 32'hAA;
            end else begin
                md_start = 1'b0; md_op = 3'd0;
            end
            @(negedge clk);
        end
        md_start = 1'b0;
        check("stall_cycles", 64'(stall_cnt), 64'd33);
        check("stall_after", {63'b0, md_stall}, 64'd0);
        check("mthi_ignored", {32'b0, hi}, 64'hFFFFFFFE);
        md_rd_en = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            logic [31:0] x, y;
            op = 3'($urandom_range(1, 6));
            x  = pick();
            y  = pick();
            if (op >= 3'd5) run_mt(op, x);
            else            run_op(op, x, y);
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the MIPS CPU. It sequences iterative 32-cycle MULT/MULTU/DIV/DIVU operations, owns the HI/LO architectural registers, services MTHI/MTLO writes, and tells the pipeline when an MFHI/MFLO read must stall. It sits beside the ALU in the execute stage. It takes its operands from the same register-file read ports that feed the ALU.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- DIV0_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- md_start  input  1  request valid this cycle.
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- md_op_x  input  32  rs operand (multiplicand/dividend/MTHI-MTLO data).
- md_op_y  input  32  rt operand (multiplier/divisor).
- md_flush  input  1  abort the in-flight operation and drop any start in the same cycle.
- md_rd_en  input  1  decode stage holds an MFHI/MFLO.
- md_busy  output  1  an iterative operation is in progress.
- md_stall  output  1  md_rd_en & md_busy (combinational).
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- **IDLE**
  - md_start with op 1–4 and no flush: latch operands and go to MUL (ops 1, 2) or DIV (ops 3, 4). Iteration counter := 0.
  - md_start with op 5: hi := md_op_x. Op 6: lo := md_op_x. State stays IDLE.
- **Signed ops (MULT, DIV)**
  - Operate on magnitudes |x| and |y|.
  - Record result sign = x[31]^y[31] and remainder sign = x[31].
- **Unsigned ops** operate on raw values with both signs = 0.
- **MUL state**
  - Shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - After 32 iterations, go to FIX.
- **DIV state**
  - Restoring division, one quotient bit per cycle.
  - After 32 iterations, go to FIX.
- **FIX state** (one cycle), then return to IDLE:
  - MUL: {hi,lo} := sign ? −acc : acc, as a 64-bit two's-complement negation.
  - DIV: lo := qsign ? −q : q and hi := rsign ? −r : r.
- **Divide by zero** (y == 0, checked at acceptance): iterations still run for timing uniformity. FIX writes lo := DIV0_LO and hi := md_op_x, with no sign correction.
- **DIV 0x80000000 / 0xFFFFFFFF**: lo = 0x80000000, hi = 0 (natural wrap; no trap).
- HI/LO change only in FIX, on MTHI/MTLO, or on reset. Intermediate values never appear on hi/lo.
- **md_start while busy**: ignored and not queued. The pipeline is responsible for stalling via md_busy.
- **md_flush while busy**: next state IDLE, busy deasserts next cycle, hi/lo keep their pre-operation values.
- **md_flush in IDLE**: any start (including MTHI/MTLO) in the same cycle is dropped.
- **rst**: overrides everything, including mid-operation. State := IDLE, hi := 0, lo := 0, counter := 0.

## Timing
- Reset values: md_busy 0, md_stall 0 (given md_rd_en = 0), hi 0, lo 0.
- Acceptance edge E0 (md_start sampled high in IDLE):
  - md_busy is high from the cycle after E0 through the FIX cycle: 33 cycles (32 iterations + FIX).
  - hi/lo hold final values and md_busy = 0 in the cycle after the FIX edge, i.e. 34 cycles after E0.
  - A back-to-back start may be accepted in that same cycle.
- MTHI/MTLO: written at the acceptance edge and visible the next cycle; md_busy never asserts.
- md_stall is combinational from md_rd_en and registered md_busy. There is no path from md_start to md_stall.
- Flush at edge Ef: md_busy is 0 in the cycle after Ef.

## Test plan
- **MULT sign/latency**: MULT 0xFFFFFFFD (−3) × 7 → after 34 cycles hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; md_busy high exactly 33 cycles.
- **MULTU unsigned**: MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- **DIV signed and overflow**:
  - DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU 100 / 7 → lo = 14, hi = 2.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero**: DIVU 0x1234 / 0 → lo = 0xFFFFFFFF, hi = 0x1234, same 33-cycle busy.
- **Flush and reset mid-op**:
  - MTLO 0x55 then MULT 3 × 3; flush at iteration 10 → busy 0 next cycle, lo = 0x55 unchanged.
  - Repeat with rst instead → hi = lo = 0.
- **Hazard/ignore**:
  - With md_rd_en = 1 during a DIV, md_stall = 1 for all 33 busy cycles and 0 on the cycle results appear.
  - MTHI 0xAA issued while busy → ignored; hi is the DIV remainder.
